// File: rtl/series_engine.sv
// Truncated power-series evaluator: result = sum of s_k*T_k with T_k = T_(k-1)*x*coef[k-1].
// One shared W x W multiplier, sequenced by an INIT/ACC/MUL_X/MUL_C state machine.
module series_engine #(
    parameter int W     = 16,
    parameter int FRAC  = 12,
    parameter int DEPTH = 8,
    localparam int NW   = $clog2(DEPTH + 2),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  x,
    input  logic [NW-1:0] n_terms,
    input  logic          alt,
    input  logic [W-1:0]  thresh,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [W-1:0]  coef_data,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic [NW-1:0] terms_used
);

    localparam logic [W-1:0]  ONE  = W'(1) << FRAC;
    localparam logic [NW-1:0] NMAX = NW'(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ACC,
        S_MUL_X,
        S_MUL_C,
        S_FINISH
    } state_t;

    state_t        state_reg;
    logic [W-1:0]  x_reg;
    logic          alt_reg;
    logic [W-1:0]  thresh_reg;
    logic [NW-1:0] n_reg;
    logic [W-1:0]  t_reg;
    logic [W-1:0]  r_reg;
    logic [NW-1:0] k_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [W-1:0]  result_reg;
    logic [NW-1:0] terms_reg;
    logic [W-1:0]  coef_reg [DEPTH];

    // Coefficient file: host writes only land while the engine is not busy.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_coef
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    coef_reg[gi] <= '0;
                end else if (coef_we && !busy_reg && (coef_addr == AW'(gi))) begin
                    coef_reg[gi] <= coef_data;
                end
            end
        end
    endgenerate

    logic [AW-1:0]         coef_idx;
    logic [W-1:0]          mul_b;
    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] prod_shift;
    logic [W-1:0]          t_mul;
    logic [W-1:0]          t_abs;
    logic [W-1:0]          r_next;
    logic [NW-1:0]         k_inc;
    logic [NW-1:0]         n_clamped;
    logic                  early_stop;
    logic                  last_term;

    // In MUL_C, k already counts the terms accumulated, so T_k uses coef[k-1].
    assign coef_idx   = AW'(k_reg - NW'(1));
    assign mul_b      = (state_reg == S_MUL_X) ? x_reg : coef_reg[coef_idx];
    assign prod       = $signed(t_reg) * $signed(mul_b);
    assign prod_shift = prod >>> FRAC;
    assign t_mul      = prod_shift[W-1:0];

    // Magnitude as unsigned W bits; the most negative value maps to 2^(W-1).
    assign t_abs      = t_reg[W-1] ? (-t_reg) : t_reg;
    assign early_stop = (thresh_reg != '0) && (t_abs < thresh_reg);
    assign k_inc      = k_reg + NW'(1);
    assign last_term  = (k_inc == n_reg);
    assign r_next     = (alt_reg && k_reg[0]) ? (r_reg - t_reg) : (r_reg + t_reg);
    assign n_clamped  = (n_terms > NMAX) ? NMAX : n_terms;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            x_reg      <= '0;
            alt_reg    <= 1'b0;
            thresh_reg <= '0;
            n_reg      <= '0;
            t_reg      <= '0;
            r_reg      <= '0;
            k_reg      <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
            terms_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        x_reg      <= x;
                        alt_reg    <= alt;
                        thresh_reg <= thresh;
                        n_reg      <= n_clamped;
                        busy_reg   <= 1'b1;
                        state_reg  <= S_INIT;
                    end
                end
                S_INIT: begin
                    t_reg <= ONE;
                    r_reg <= '0;
                    k_reg <= '0;
                    if (n_reg == '0) begin
                        // r still holds the previous run here, so report zero directly.
                        result_reg <= '0;
                        terms_reg  <= '0;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= S_FINISH;
                    end else begin
                        state_reg <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_reg <= r_next;
                    k_reg <= k_inc;
                    if (last_term || early_stop) begin
                        result_reg <= r_next;
                        terms_reg  <= k_inc;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= S_FINISH;
                    end else begin
                        state_reg <= S_MUL_X;
                    end
                end
                S_MUL_X: begin
                    t_reg     <= t_mul;
                    state_reg <= S_MUL_C;
                end
                S_MUL_C: begin
                    t_reg     <= t_mul;
                    state_reg <= S_ACC;
                end
                S_FINISH: begin
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign result     = result_reg;
    assign terms_used = terms_reg;

endmodule

// File: tb/tb_series_engine.sv
// Directed bench for series_engine: table of evaluations plus protocol and reset sequences.
module tb_series_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] x;
    logic [3:0]  n_terms;
    logic        alt;
    logic [15:0] thresh;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [15:0] coef_data;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  terms_used;

    int total = 0;
    int bad   = 0;

    series_engine #(.W(16), .FRAC(12), .DEPTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .x          (x),
        .n_terms    (n_terms),
        .alt        (alt),
        .thresh     (thresh),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .terms_used (terms_used)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [3:0]  n;
        logic        alt;
        logic [15:0] th;
        logic [15:0] res;
        logic [3:0]  tu;
        int          dc;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    // mode 1: start pulsed mid-run and during FINISH; mode 2: coef[1] write mid-run.
    task automatic run_eval(input logic [15:0] xv, input logic [3:0] nv, input logic altv,
                            input logic [15:0] th, input int mode,
                            output int dc, output int busy_bad, output int extra,
                            output logic [15:0] res, output logic [3:0] tu);
        int cyc;
        @(negedge clk);
        x = xv; n_terms = nv; alt = altv; thresh = th; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; dc = -1; busy_bad = 0; extra = 0; res = '0; tu = '0;
        while (dc < 0 && cyc < 200) begin
            if (done) begin
                dc  = cyc;
                res = result;
                tu  = terms_used;
                if (busy) busy_bad++;
            end else begin
                if (!busy) busy_bad++;
                if (mode == 1 && cyc == 4) start = 1'b1;
                if (mode == 1 && cyc == 6) start = 1'b0;
                if (mode == 2 && cyc == 3) begin
                    coef_we = 1'b1; coef_addr = 3'd1; coef_data = 16'd0;
                end
                if (mode == 2 && cyc == 4) coef_we = 1'b0;
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (mode == 1) start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done || busy) extra++;
        end
    endtask

    initial begin
        int dc, bb, ex, quiet;
        logic [15:0] res;
        logic [3:0]  tu;

        vecs[0] = '{16'd2048, 4'd6,  1'b0, 16'd0,      16'd6751, 4'd6, 18};
        vecs[1] = '{16'd2048, 4'd6,  1'b1, 16'd0,      16'd2485, 4'd6, 18};
        vecs[2] = '{16'd2048, 4'd8,  1'b0, 16'd50,     16'd6751, 4'd5, 15};
        vecs[3] = '{16'd2048, 4'd0,  1'b0, 16'd0,      16'd0,    4'd0, 2};
        vecs[4] = '{16'd2048, 4'd15, 1'b0, 16'd0,      16'd6751, 4'd9, 27};
        vecs[5] = '{16'hFFFF, 4'd2,  1'b0, 16'd0,      16'd4095, 4'd2, 6};
        vecs[6] = '{16'd2048, 4'd8,  1'b0, 16'd10,     16'd6751, 4'd6, 18};
        vecs[7] = '{16'd2048, 4'd8,  1'b0, 16'hFFFF,   16'd4096, 4'd1, 3};

        rst_n = 1'b0; start = 1'b0; x = '0; n_terms = '0; alt = 1'b0; thresh = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_result", int'(result), 0);
        chk("reset_terms", int'(terms_used), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Coefficients come out of reset as zero, so T1 vanishes.
        run_eval(16'd2048, 4'd2, 1'b0, 16'd0, 0, dc, bb, ex, res, tu);
        $display("zero-coef run: result=%0d terms=%0d done_cycle=%0d", res, tu, dc);
        chk("zero_coef_result", int'(res), 4096);
        chk("zero_coef_done_cycle", dc, 6);

        write_coef(3'd0, 16'd4096); write_coef(3'd1, 16'd2048);
        write_coef(3'd2, 16'd1365); write_coef(3'd3, 16'd1024);
        write_coef(3'd4, 16'd819);  write_coef(3'd5, 16'd683);
        write_coef(3'd6, 16'd585);  write_coef(3'd7, 16'd512);

        for (int i = 0; i < 8; i++) begin
            run_eval(vecs[i].x, vecs[i].n, vecs[i].alt, vecs[i].th, 0, dc, bb, ex, res, tu);
            $display("vec %0d: x=%h n=%0d alt=%0d th=%0d -> result=%0d terms=%0d done_cycle=%0d",
                     i, vecs[i].x, vecs[i].n, vecs[i].alt, vecs[i].th, res, tu, dc);
            chk($sformatf("vec%0d_result", i), int'(res), int'(vecs[i].res));
            chk($sformatf("vec%0d_terms", i), int'(tu), int'(vecs[i].tu));
            chk($sformatf("vec%0d_done_cycle", i), dc, vecs[i].dc);
            chk($sformatf("vec%0d_busy_profile", i), bb, 0);
            chk($sformatf("vec%0d_after_done", i), ex, 0);
        end

        run_eval(16'd2048, 4'd3, 1'b0, 16'd0, 1, dc, bb, ex, res, tu);
        $display("start-while-busy run: result=%0d done_cycle=%0d extra=%0d", res, dc, ex);
        chk("busy_start_result", int'(res), 6656);
        chk("busy_start_done_cycle", dc, 9);
        chk("busy_start_no_restart", ex, 0);

        run_eval(16'd2048, 4'd3, 1'b0, 16'd0, 2, dc, bb, ex, res, tu);
        $display("coef-write-while-busy run: result=%0d done_cycle=%0d", res, dc);
        chk("busy_write_result", int'(res), 6656);
        chk("busy_write_done_cycle", dc, 9);

        // Reset asserted while the engine sits in MUL_X (cycle 3).
        @(negedge clk);
        x = 16'd2048; n_terms = 4'd6; alt = 1'b0; thresh = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        $display("reset in MUL_X: busy=%0d done=%0d result=%0d terms=%0d", busy, done, result, terms_used);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_done", int'(done), 0);
        chk("midreset_result", int'(result), 0);
        chk("midreset_terms", int'(terms_used), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done || busy) quiet++;
        end
        chk("midreset_no_done", quiet, 0);

        run_eval(16'd2048, 4'd2, 1'b0, 16'd0, 0, dc, bb, ex, res, tu);
        $display("post-reset run: result=%0d terms=%0d done_cycle=%0d", res, tu, dc);
        chk("midreset_coef_cleared", int'(res), 4096);
        chk("midreset_rerun_terms", int'(tu), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
